// File: rtl/fetch_unit_if.sv
// fetch_unit_if: hazard, branch, imem and IF/ID bundle for fetch_unit.
// FETCH_PERF_EN adds the perfFetched/perfBubbles counter outputs.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
);
  logic               stopSignal;
  logic               selectPCMux;
  logic [ADDR_W-1:0]  branchTarget;
  logic               stallIn;
  logic [INSTR_W-1:0] instrData;
  logic [ADDR_W-1:0]  instrAddr;
  logic [INSTR_W-1:0] ifidInstr;
  logic [ADDR_W-1:0]  ifidPc;
  logic               ifidValid;
  logic               flushOut;
  logic               halted;
`ifdef FETCH_PERF_EN
  logic [31:0]        perfFetched;
  logic [31:0]        perfBubbles;
`endif

  modport master (
    input  stopSignal,
    input  selectPCMux,
    input  branchTarget,
    input  stallIn,
    input  instrData,
    output instrAddr,
    output ifidInstr,
    output ifidPc,
    output ifidValid,
    output flushOut,
`ifdef FETCH_PERF_EN
    output perfFetched,
    output perfBubbles,
`endif
    output halted
  );

  modport slave (
    output stopSignal,
    output selectPCMux,
    output branchTarget,
    output stallIn,
    output instrData,
    input  instrAddr,
    input  ifidInstr,
    input  ifidPc,
    input  ifidValid,
    input  flushOut,
`ifdef FETCH_PERF_EN
    input  perfFetched,
    input  perfBubbles,
`endif
    input  halted
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC, imem address and IF/ID register with redirect/stall/HALT.
// FETCH_PERF_EN adds fetched-instruction and bubble counters.
module fetch_unit #(
  parameter int unsigned  ADDR_W      = 32,
  parameter int unsigned  INSTR_W     = 32,
  parameter int unsigned  PC_STEP     = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [3:0]         HALT_OPCODE = 4'b1111,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic               flush_q, flush_d;

  logic       redir;
  logic       hold;
  logic       idle;
  logic       fetch;
  logic [3:0] opcode;
  logic       is_halt;

  // One-hot rule select: redirect beats hold beats halt-idle beats fetch.
  assign redir   = bus.selectPCMux;
  assign hold    = !redir && (bus.stopSignal || bus.stallIn);
  assign idle    = !redir && !hold && (state_q == HALT);
  assign fetch   = !redir && !hold && (state_q == RUN);
  assign opcode  = bus.instrData[INSTR_W-1 -: 4];
  assign is_halt = (opcode == HALT_OPCODE);

  // Next PC, IF/ID contents, flush and FSM state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    flush_d      = 1'b0;
    unique case (1'b1)
      redir: begin
        pc_d         = bus.branchTarget;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
        flush_d      = 1'b1;
        state_d      = RUN;
      end
      hold: begin
        flush_d = 1'b0;
      end
      idle: begin
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end
      fetch: begin
        ifid_instr_d = bus.instrData;
        ifid_pc_d    = pc_q;
        ifid_valid_d = 1'b1;
        if (is_halt) begin
          state_d = HALT;
        end else begin
          pc_d = pc_q + ADDR_W'(PC_STEP);
        end
      end
      default: begin
        flush_d = 1'b0;
      end
    endcase
  end

  // State and IF/ID registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      flush_q      <= flush_d;
    end
  end

  assign bus.instrAddr = pc_q;
  assign bus.ifidInstr = ifid_instr_q;
  assign bus.ifidPc    = ifid_pc_q;
  assign bus.ifidValid = ifid_valid_q;
  assign bus.flushOut  = flush_q;
  assign bus.halted    = (state_q == HALT);

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] bubbles_q, bubbles_d;

  // Count real fetches and bubble loads; both freeze while held.
  always_comb begin
    fetched_d = fetched_q + 32'(fetch);
    bubbles_d = bubbles_q + 32'(redir || idle);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign bus.perfFetched = fetched_q;
  assign bus.perfBubbles = bubbles_q;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the vector encryption CPU. Holds the program counter, drives the instruction-memory address and fills the IF/ID pipeline register. It consumes `stopSignal` and `selectPCMux` from the hazard unit and `branchTarget` from the execute stage, then redirects, holds or advances the PC. It also stops fetching permanently after a HALT instruction.

## Interface
- `ADDR_W`, 32: PC and instruction-address width.
- `INSTR_W`, 32: instruction width; the opcode is `instrData[INSTR_W-1 -: 4]`.
- `PC_STEP`, 4: PC increment per fetched instruction.
- `RESET_PC`, 0: PC value after reset.
- `HALT_OPCODE`, 4'b1111: opcode that stops fetching.
- `NOP_INSTR`, 0: instruction word inserted for bubbles.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stopSignal`  in  1  hazard-unit stop request.
- `selectPCMux`  in  1  hazard-unit redirect select: 1 loads `branchTarget`.
- `branchTarget`  in  ADDR_W  taken-branch destination.
- `stallIn`  in  1  external stall, e.g. a multi-cycle vector op.
- `instrData`  in  INSTR_W  instruction memory read data, combinational from `instrAddr`.
- `instrAddr`  out  ADDR_W  equals current PC.
- `ifidInstr`  out  INSTR_W  IF/ID instruction.
- `ifidPc`  out  ADDR_W  PC of `ifidInstr`.
- `ifidValid`  out  1  IF/ID holds a real instruction.
- `flushOut`  out  1  registered; 1 for the cycle after a redirect, kills the ID/EX entry downstream.
- `halted`  out  1  FSM is in HALT.

## Operation
- FSM states:
  - RUN: fetching.
  - HALT: fetch stopped.
- Each rising edge applies the first matching rule below, in priority order:
  1. `selectPCMux`=1 (in any state):
     - `pc <= branchTarget`; `ifidValid <= 0`; `ifidInstr <= NOP_INSTR`; `ifidPc` holds.
     - `flushOut <= 1`; FSM goes to RUN.
     - The redirect wins over `stallIn` and overrides HALT, because the branch is older than the halt.
  2. `stopSignal`=1 with `selectPCMux`=0, or `stallIn`=1: `pc` and all IF/ID outputs hold; `flushOut <= 0`.
  3. HALT: `pc` holds; `ifidValid <= 0`; `ifidInstr <= NOP_INSTR`; `flushOut <= 0`.
  4. RUN, normal fetch:
     - `ifidInstr <= instrData`; `ifidPc <= pc`; `ifidValid <= 1`; `flushOut <= 0`.
     - If the opcode equals `HALT_OPCODE`: `pc` holds and the FSM goes to HALT. The halt word itself is passed to IF/ID as valid.
     - Otherwise `pc <= pc + PC_STEP`.
- PC arithmetic is modulo 2^ADDR_W. `RESET_PC + k*PC_STEP` wraps silently.
- `branchTarget` is used unmodified; there is no alignment check.
- `instrAddr = pc`, combinational.

## Timing
- Reset (asynchronous, any time, including mid-redirect):
  - `pc`=`RESET_PC`, `ifidInstr`=`NOP_INSTR`, `ifidPc`=0, `ifidValid`=0, `flushOut`=0, `halted`=0, FSM=RUN.
- First valid IF/ID entry appears 1 cycle after `rst` deasserts.
- Fetch-to-IF/ID latency: 1 cycle. Throughput: 1 instruction/cycle when not stalled.
- Taken-branch penalty:
  - In the redirect cycle, `ifidValid` goes to 0 and `flushOut` to 1.
  - The instruction at `branchTarget` is in IF/ID one cycle later, with `ifidValid`=1.
- `halted` rises on the edge that captures the HALT word.
- Redirect out of HALT: `halted` falls on the same edge.

## Configuration
- `FETCH_PERF_EN` defined adds:
  - Output `perfFetched` (32 bits): counts edges where rule 4 loads a valid instruction.
  - Output `perfBubbles` (32 bits): counts edges where `ifidValid` is loaded with 0 (rules 1 and 3).
  - Both counters reset to 0, wrap at 2^32, and hold during rule 2.
- `FETCH_PERF_EN` undefined: neither port nor any counter logic exists.

## Test plan
- Reset then free run, with `instrData` = 0x1000_0000 + addr:
  - Cycle 1: `ifidPc`=0, `ifidInstr`=0x1000_0000.
  - Cycle 2: `ifidPc`=4.
  - `instrAddr` increments by 4 each cycle.
- Taken branch: at PC 0x10, pulse `stopSignal`=`selectPCMux`=1 for 1 cycle with `branchTarget`=0x80:
  - Next cycle: `ifidValid`=0, `flushOut`=1, `instrAddr`=0x80.
  - Following cycle: `ifidPc`=0x80, `ifidValid`=1.
- `stallIn` high for 3 cycles at PC 0x20: `instrAddr` stays 0x20 and IF/ID is frozen; fetch resumes at 0x20.
- `stopSignal`=1 alone for 2 cycles: behaves exactly like `stallIn`, and `flushOut` stays 0.
- HALT word (opcode 4'b1111) at 0x40:
  - `ifidPc`=0x40 and valid, then `ifidValid`=0 and `halted`=1, with `instrAddr` stuck at 0x40.
  - A redirect to 0x0 then clears `halted` and fetch resumes at 0x0.
- Boundary cases:
  - Redirect coincident with `stallIn`: the redirect wins.
  - `branchTarget`=0xFFFF_FFFC followed by a normal fetch: PC wraps to 0x0.
  - `rst` asserted mid-redirect: all outputs return to reset values immediately.
